instruction_fetch_buffer: RTL and testbench
===========================================

// Module: instruction_fetch_buffer
// PURPOSE
//  Decoupled fetch front-end: owns the fetch PC, streams sequential requests to a
//  variable-latency instruction memory, and buffers returned words in a small FIFO.
//  Feeds (pc, instr) pairs to decode over a valid/ready handshake.
//  Branch/jump redirect from execute flushes the buffer and squashes in-flight responses.
// PARAMETERS
//  DEPTH     4      FIFO entries; also the cap on FIFO count + outstanding requests (power of 2, >=2)
//  XLEN      64     PC / address width
//  RESET_PC  64'h0  fetch and head PC after reset
// PORTS
//  clk             in   1     clock; all state updates on posedge
//  reset           in   1     synchronous, active-high
//  redirect_valid  in   1     taken branch/jump; flush and refetch
//  redirect_pc     in   XLEN  new fetch target; bits [1:0] forced to 0
//  imem_req_valid  out  1     fetch request valid
//  imem_req_addr   out  XLEN  fetch address (= fetch_pc)
//  imem_req_ready  in   1     memory accepts request this cycle
//  imem_resp_valid in   1     response word valid; responses return in request order
//  imem_resp_data  in   32    instruction word
//  out_valid       out  1     FIFO head valid to decode
//  out_instr       out  32    FIFO head instruction
//  out_pc          out  XLEN  PC of head instruction (= head_pc)
//  out_ready       in   1     decode consumes head this cycle
// BEHAVIOUR
//  State: fetch_pc, head_pc, count (0..DEPTH), inflight (0..DEPTH), drop_cnt (0..DEPTH), FIFO.
//  Reset (sync): fetch_pc=head_pc=RESET_PC; count=inflight=drop_cnt=0; out_valid=0,
//   imem_req_valid=0 while reset high; FIFO contents don't-care. Reset overrides redirect.
//  Request: imem_req_valid = !reset && (count + inflight < DEPTH). Handshake (valid&ready)
//   -> fetch_pc += 4, inflight += 1. No reordering; no alignment faults raised.
//  Response: imem_resp_valid -> inflight -= 1. If drop_cnt>0: discard word, drop_cnt -= 1.
//   Else push imem_resp_data into FIFO (count += 1). Overflow impossible by credit rule;
//   a response with inflight==0 is a protocol error (assertion, word ignored).
//  Output: out_valid = (count != 0); dequeue on out_valid&out_ready -> count -= 1, head_pc += 4.
//   Latency: response in cycle N -> visible on out_* in N+1 (registered FIFO, no bypass).
//  Same-cycle push+pop: count unchanged, both take effect.
//  Redirect (priority over normal update, below reset):
//   - FIFO emptied (count=0); any same-cycle dequeue and push are discarded.
//   - fetch_pc = head_pc = {redirect_pc[XLEN-1:2],2'b00}.
//   - drop_cnt = inflight_next (inflight after this cycle's req/resp accounting, so a request
//     accepted in the redirect cycle is stale and will be dropped); a response arriving in the
//     redirect cycle is discarded, not counted in drop_cnt.
//   - Back-to-back redirects: each recomputes drop_cnt from current inflight; last target wins.
//  Credit during drop: dropped responses still occupy inflight, so new requests stall until
//   count + inflight < DEPTH; no stale word can ever reach the FIFO.
//  Widths: PC arithmetic modulo 2^XLEN (wraps silently at top of address space).
// STRUCTURE
//  Shared package: XLEN default, INSTR_W=32, PC_STEP=4, NOP encoding 32'h00000013.
//  One sub-module: sync_fifo #(DEPTH, WIDTH=INSTR_W) with push/pop/flush, count, full/empty.
//  Counters (inflight, drop_cnt) and PC registers live in the top module.
// TESTING
//  1 Reset, mem 1-cycle latency, out_ready=1 -> addrs 0,4,8.. issued; out_pc 0,4,8 with matching words.
//  2 out_ready=0, latency 1 -> exactly DEPTH=4 requests then imem_req_valid=0; count=4; release ->
//    drains 4, requests resume.
//  3 Latency 3, redirect to 0x100 with inflight=2 -> 2 responses dropped; first out_pc=0x100.
//  4 Redirect same cycle as req handshake and a response -> response dropped, accepted req dropped
//    later; out_instr never carries pre-redirect data.
//  5 redirect_pc=0x103 -> imem_req_addr=0x100, out_pc=0x100.
//  6 reset asserted mid-stream with inflight=3 and redirect_valid=1 -> next cycle all counters 0,
//    out_valid=0, fetch_pc=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_buffer_pkg.sv
// Shared definitions for the instruction fetch buffer.
// Contents: default address width, instruction width, sequential PC step and the
//   NOP encoding presented on out_instr whenever the buffer has nothing to offer.
package instruction_fetch_buffer_pkg;

  localparam int XLEN_DEF = 64;
  localparam int INSTR_W  = 32;
  localparam int PC_STEP  = 4;

  // addi x0, x0, 0
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instruction_fetch_buffer_fifo.sv
// Purpose: single-clock FIFO holding fetched instruction words; flush empties it in one cycle.
// Ports: clk/reset (sync, active-high); push/push_data write, pop retires the head,
//   flush discards everything (including same-cycle push/pop); head_data, count, full, empty.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok && !flush && !reset) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch_buffer.sv
// Purpose: fetch front-end; owns fetch PC, issues sequential imem requests, buffers words for decode.
// Ports: clk/reset; redirect_valid/redirect_pc from execute; imem_req_* / imem_resp_* to memory;
//   out_valid/out_instr/out_pc/out_ready to decode. Response in cycle N is visible on out_* in N+1.
module instruction_fetch_buffer
  import instruction_fetch_buffer_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req_valid,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc,
  input  logic               out_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0]    fetch_pc;
  logic [XLEN-1:0]    head_pc;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      inflight_next;
  logic [CW-1:0]      drop_cnt;
  logic [CW-1:0]      count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [INSTR_W-1:0] fifo_head;
  logic [XLEN-1:0]    redirect_tgt;

  logic req_fire;
  logic resp_take;
  logic resp_drop;
  logic fifo_push;
  logic fifo_pop;

  assign redirect_tgt = redirect_pc & ~XLEN'(3);

  // Credit rule: every outstanding request owns a FIFO slot, so a returned word always fits.
  // The sum is widened by one bit so count + inflight cannot wrap.
  assign imem_req_valid = !reset && !fifo_full &&
                          (({1'b0, count} + {1'b0, inflight}) < (CW + 1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_take = imem_resp_valid && (inflight != '0);
  assign resp_drop = resp_take && (drop_cnt != '0);

  assign inflight_next = inflight + CW'(req_fire) - CW'(resp_take);

  // Redirect throws away both the incoming word and any same-cycle dequeue.
  assign fifo_push = resp_take && !resp_drop && !redirect_valid;
  assign fifo_pop  = out_valid && out_ready && !redirect_valid;

  assign out_valid = !reset && !fifo_empty;
  assign out_instr = out_valid ? fifo_head : NOP_INSTR;
  assign out_pc    = head_pc;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (imem_resp_data),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .head_data (fifo_head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_tgt;
        head_pc  <= redirect_tgt;
        // Everything still outstanding after this cycle, including a request accepted
        // right now, belongs to the old path and must be discarded when it returns.
        drop_cnt <= inflight_next;
      end else begin
        if (req_fire)  fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        if (fifo_pop)  head_pc  <= head_pc + XLEN'(PC_STEP);
        if (resp_drop) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // Memory must never return more words than were requested.
  always_ff @(posedge clk) begin
    if (!reset && imem_resp_valid) begin
      assert (inflight != '0);
    end
  end

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Bench for instruction_fetch_buffer: random memory latency, handshakes and redirects,
// checked every cycle against an epoch-tagged model of the expected instruction stream.
module tb_instruction_fetch_buffer;

  localparam int          DEPTH    = 4;
  localparam int          XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready;

  always #5 clk = ~clk;

  instruction_fetch_buffer #(
    .DEPTH    (DEPTH),
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_ready       (out_ready)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] addr;
    int          epoch;
    int          rdy;
  } req_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] w;
  } ent_t;

  req_t        mem_q[$];   // requests accepted by memory, in order
  ent_t        fifo_m[$];  // words decode should see, in order
  int          epoch;
  int          last_rdy;
  int          cyc;
  logic [63:0] exp_fetch;

  // knobs
  int p_rdy, p_out, p_redir, lat_min, lat_max;
  bit rst_drive;

  int n_cmp, n_bad;

  // Unique word per address (odd multiplier is a bijection on 32 bits).
  function automatic logic [31:0] memword(logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0] * 32'h9E37_79B1;
    return lo ^ a[63:32];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] rand_target();
    logic [63:0] t;
    if ($urandom_range(9) == 0) t = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(31));
    else                        t = 64'($urandom_range(16'hFFFF));
    return t;
  endfunction

  // One clock cycle: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic step(input bit frc, input logic [63:0] ftgt);
    bit   exp_rv, exp_ov, fire, pop, resp, redir;
    req_t r;
    int   lat, rd;
    reset          = rst_drive;
    imem_req_ready = ($urandom_range(99) < p_rdy);
    out_ready      = ($urandom_range(99) < p_out);
    redir          = frc || ($urandom_range(99) < p_redir);
    redirect_valid = redir;
    redirect_pc    = frc ? ftgt : rand_target();
    resp           = !rst_drive && (mem_q.size() != 0) && (mem_q[0].rdy <= cyc);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? memword(mem_q[0].addr) : $urandom;

    @(negedge clk);
    exp_rv = !rst_drive && (fifo_m.size() + mem_q.size() < DEPTH);
    exp_ov = !rst_drive && (fifo_m.size() != 0);
    check("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    if (exp_rv) check("req_addr", imem_req_addr, exp_fetch);
    check("out_valid", 64'(out_valid), 64'(exp_ov));
    if (exp_ov) begin
      check("out_pc", out_pc, fifo_m[0].pc);
      check("out_instr", 64'(out_instr), 64'(fifo_m[0].w));
    end
    fire = exp_rv && imem_req_ready;
    pop  = exp_ov && out_ready;

    @(posedge clk);
    if (rst_drive) begin
      mem_q.delete();
      fifo_m.delete();
      epoch++;
      exp_fetch = RESET_PC;
      last_rdy  = 0;
    end else begin
      if (resp) r = mem_q.pop_front();
      if (pop && !redir) void'(fifo_m.pop_front());
      if (resp && !redir && r.epoch == epoch) fifo_m.push_back('{r.addr, memword(r.addr)});
      if (fire) begin
        lat = $urandom_range(lat_max, lat_min);
        rd  = (cyc + lat > last_rdy) ? cyc + lat : last_rdy;
        last_rdy = rd;
        mem_q.push_back('{exp_fetch, epoch, rd});
        exp_fetch = exp_fetch + 64'd4;
      end
      if (redir) begin
        fifo_m.delete();
        epoch++;
        exp_fetch = ftgt_or(frc, ftgt, redirect_pc);
      end
    end
    cyc++;
    #1;
  endtask

  function automatic logic [63:0] ftgt_or(bit frc, logic [63:0] f, logic [63:0] d);
    logic [63:0] t;
    t = frc ? f : d;
    return {t[63:2], 2'b00};
  endfunction

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 64'h0);
  endtask

  task automatic set_knobs(input int rdy, input int outp, input int red, input int lmin, input int lmax);
    p_rdy = rdy; p_out = outp; p_redir = red; lat_min = lmin; lat_max = lmax;
  endtask

  initial begin
    bit hit;
    n_cmp = 0; n_bad = 0; cyc = 0; epoch = 0; last_rdy = 0;
    exp_fetch = RESET_PC;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; out_ready = 1'b0;
    set_knobs(100, 100, 0, 1, 1);
    rst_drive = 1'b1;
    @(posedge clk); #1;
    run(2);
    rst_drive = 1'b0;

    // Streaming with 1-cycle memory.
    run(20);

    // Decode stalled: buffer fills to DEPTH, requests stop; then drain.
    set_knobs(100, 0, 0, 1, 1);
    run(12);
    set_knobs(100, 100, 0, 1, 1);
    run(12);

    // Latency 3, redirect to 0x100 with two requests outstanding.
    set_knobs(100, 100, 0, 3, 3);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (mem_q.size() == 2) begin step(1'b1, 64'h100); hit = 1; end
      else step(1'b0, 64'h0);
    end
    check("wait_inflight2", 64'(hit), 64'd1);
    run(15);

    // Redirect in the same cycle as a request handshake and a response.
    set_knobs(100, 100, 0, 1, 2);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (mem_q.size() != 0 && mem_q[0].rdy <= cyc && fifo_m.size() + mem_q.size() < DEPTH) begin
        step(1'b1, 64'h2000); hit = 1;
      end else step(1'b0, 64'h0);
    end
    check("wait_collide", 64'(hit), 64'd1);
    run(15);

    // Unaligned redirect target, then a target near the top of the address space.
    step(1'b1, 64'h103);
    run(12);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFF4);
    run(12);

    // Back-to-back redirects.
    set_knobs(100, 100, 0, 2, 4);
    run(6);
    step(1'b1, 64'h400);
    step(1'b1, 64'h800);
    run(20);

    // Random mix.
    set_knobs(70, 70, 4, 1, 5);
    run(2500);

    // Reset mid-stream with three outstanding and a redirect in the same cycle.
    set_knobs(100, 100, 0, 4, 4);
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      if (mem_q.size() == 3) begin
        rst_drive = 1'b1;
        step(1'b1, 64'h3000);
        rst_drive = 1'b0;
        hit = 1;
      end else step(1'b0, 64'h0);
    end
    check("wait_inflight3", 64'(hit), 64'd1);
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
